sd_dat_tx: RTL and testbench
============================

Name: sd_dat_tx

Overview:
Parametrised SD host data-write engine. It serialises one data block of programmable length onto the DAT lines in 1-bit or 4-bit bus mode. Per block it generates the start bit, per-line CRC16 and end bit, then receives the card's CRC status token and waits out card busy on DAT0. It sits between the host data FIFO (valid/ready word interface) and the SD pad drivers, and runs entirely in the SD clock domain.

Parameters:
BlockLenWidth, 12, width of block_len_i in bytes; maximum block is 2^BlockLenWidth-4 bytes.
StatusTimeout, 8, SD clocks allowed after the end bit for the CRC status start bit to appear.

Ports:
sd_clk_i  in  1  SD clock; all logic on rising edge.
rst_i  in  1  synchronous reset, active-high.
start_i  in  1  single-cycle request to begin one block; accepted only in IDLE.
bus_4bit_i  in  1  1 = 4-line mode, 0 = 1-line mode (DAT0 only); sampled on accepted start_i.
block_len_i  in  BlockLenWidth  block length in bytes; bits [1:0] ignored; sampled on accepted start_i.
stop_i  in  1  abort request (stop command end bit was sent the previous cycle).
dat_i  in  32  data word; byte 0 = dat_i[7:0] is transmitted first.
dat_valid_i  in  1  dat_i valid.
dat_ready_o  out  1  word accepted when dat_valid_i && dat_ready_o.
dat_o  out  4  values driven onto DAT[3:0].
dat_oe_o  out  4  per-line output enable.
dat0_i  in  1  sampled DAT0 from the card.
busy_o  out  1  high whenever state != IDLE.
done_o  out  1  one-cycle pulse on return to IDLE after a start.
status_o  out  3  last CRC status token; held until the next token.
crc_err_o  out  1  pulse coincident with done_o on bad token or timeout.
underflow_o  out  1  one-cycle pulse when a word was not available in time.

Behaviour:
- Reset: state IDLE; dat_o=4'hF, dat_oe_o=0, dat_ready_o=0, busy_o=0, done_o=0, status_o=0, crc_err_o=0, underflow_o=0; word buffer empty; CRC registers cleared. Reset mid-block releases the bus on the next edge.
- Active lanes: 4'hF in 4-bit mode, 4'h1 in 1-bit mode. dat_oe_o equals the active lanes in START, DATA, CRC and END, and is 0 otherwise. Inactive lanes drive 1.
- Storage: one 32-bit holding buffer plus one shift register. dat_ready_o = buffer empty && state in {FETCH, START, DATA} && words requested < block words.
- FSM:
  - IDLE: start_i && !stop_i && block_len_i[BlockLenWidth-1:2]!=0 -> FETCH. Otherwise stay. start_i while not IDLE is ignored.
  - FETCH: bus released. Wait (unbounded) for the first word. On handshake, load the word directly into the shift register -> START. stop_i -> IDLE with no done_o.
  - START: one cycle driving 0 on the active lanes -> DATA.
  - DATA: one bit-slot per cycle.
    - 4-bit order: dat[7:4], dat[3:0], dat[15:12], ..., dat[27:24]; lane k carries nibble bit k; 8 cycles/word.
    - 1-bit order: dat[7]..dat[0], dat[15]..dat[8], ...; 32 cycles/word.
    - In the last slot of a word: if words remain and the buffer is full, the shift register loads from the buffer. If the buffer is empty, pulse underflow_o and go to END.
    - Last slot of the last word -> CRC.
  - CRC: 16 cycles. Each active lane shifts out its CRC16 MSB first -> END.
  - END: one cycle driving 1. Normal completion -> STAT_WAIT. Stop or underflow -> IDLE with done_o.
  - STAT_WAIT: bus released. dat0_i==0 -> STAT. Otherwise, after StatusTimeout cycles -> IDLE with done_o, crc_err_o=1, status_o=3'b000.
  - STAT: sample 3 token bits MSB first into status_o, then one end-bit cycle (value ignored) -> BUSY.
  - BUSY: stay while dat0_i==0. On dat0_i==1 -> IDLE with done_o. crc_err_o = (status_o != 3'b010).
- CRC16: polynomial x^16+x^12+x^5+1, init 0, one lane per line, updated with each DATA bit of that lane; cleared on entry to START.
- stop_i in START, DATA or CRC: END on the next cycle. stop_i is ignored in END, STAT_WAIT, STAT and BUSY.
- Latency, 512 B block: 4-bit = 1 START + 1024 DATA + 16 CRC + 1 END; 1-bit = 1 + 4096 + 16 + 1.

Test Plan:
- 1-bit mode, 512 B of 0xFF; card returns token 010 then 5 busy cycles -> DAT0 shows 0, then 4096 ones, then CRC 0x7FA1, then 1; status_o=010; done_o pulses; crc_err_o=0.
- 4-bit mode, 512 B of incrementing words 0x03020100.. -> first DATA slots show 4'h0,4'h0,4'h0,4'h1; per-lane CRC matches the bench model; 1042 driven cycles in total.
- 4-bit mode, 8 B block; card returns token 101 -> status_o=101; crc_err_o and done_o pulse together.
- Withhold dat_valid_i after the first word (4-bit, 16 B) -> underflow_o pulses at DATA slot 7; one END cycle; no status phase; done_o pulses.
- stop_i at DATA cycle 100 -> END driven the next cycle; IDLE and done_o the cycle after; dat_oe_o=0.
- Card never drives DAT0 low after END -> timeout after StatusTimeout=8 cycles; crc_err_o=1; status_o=000. Also: rst_i mid-DATA -> dat_oe_o=0 on the next edge.

Source files
------------

// File: rtl/sd_dat_tx.sv
// SD host block-write engine: start bit, 1/4-lane data with per-lane CRC16, end bit, then CRC status token and busy wait.
// Latency is 1 + 8*words (4-bit) or 1 + 32*words (1-bit) + 16 + 1 driven cycles; the word input stalls on dat_ready_o and a late word aborts with underflow_o.
module sd_dat_tx #(
   parameter int BlockLenWidth = 12,
   parameter int StatusTimeout = 8
) (
   input  logic                     sd_clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     bus_4bit_i,
   input  logic [BlockLenWidth-1:0] block_len_i,
   input  logic                     stop_i,
   input  logic [31:0]              dat_i,
   input  logic                     dat_valid_i,
   output logic                     dat_ready_o,
   output logic [3:0]               dat_o,
   output logic [3:0]               dat_oe_o,
   input  logic                     dat0_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [2:0]               status_o,
   output logic                     crc_err_o,
   output logic                     underflow_o
);

   localparam int WW = BlockLenWidth - 2;
   localparam int TW = $clog2(StatusTimeout + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_START, S_DATA, S_CRC, S_END, S_STAT_WAIT, S_STAT, S_BUSY
   } state_t;

   state_t          state, state_nxt;
   logic            bus4;
   logic [WW-1:0]   words_total, words_req, words_sent;
   logic [31:0]     hold_dat, shreg;
   logic            hold_full;
   logic [4:0]      bit_cnt;
   logic [3:0]      crc_cnt;
   logic [TW-1:0]   to_cnt;
   logic [1:0]      stat_cnt;
   logic [1:0]      tok;
   logic            abort;
   logic [15:0]     crc_q [4];
   logic [2:0]      status_q;
   logic            done_q, crc_err_q;

   logic            start_ok, word_hs, last_slot, last_word, underflow, timeout;
   logic [3:0]      lanes, data_bits, crc_bits;
   logic            unused_len_lsbs;

   assign unused_len_lsbs = ^block_len_i[1:0];

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
   endfunction

   // Byte 0 goes to the top so both bus widths shift out MSB first.
   function automatic logic [31:0] byte_rev(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign start_ok  = start_i && !stop_i && (block_len_i[BlockLenWidth-1:2] != '0);
   assign word_hs   = dat_valid_i && dat_ready_o;
   assign last_slot = bus4 ? (bit_cnt == 5'd7) : (bit_cnt == 5'd31);
   assign last_word = (words_sent == words_total - WW'(1));
   assign underflow = (state == S_DATA) && last_slot && !last_word && !hold_full && !stop_i;
   assign timeout   = dat0_i && (to_cnt == TW'(StatusTimeout - 1));
   assign lanes     = bus4 ? 4'hF : 4'h1;
   assign data_bits = bus4 ? shreg[31:28] : {3'b111, shreg[31]};
   assign crc_bits  = bus4 ? {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]}
                           : {3'b111, crc_q[0][15]};

   always_ff @(posedge sd_clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (start_ok) state_nxt = S_FETCH;
         S_FETCH:     if (stop_i) state_nxt = S_IDLE;
                      else if (word_hs) state_nxt = S_START;
         S_START:     state_nxt = stop_i ? S_END : S_DATA;
         S_DATA:      if (stop_i) state_nxt = S_END;
                      else if (last_slot) begin
                         if (last_word)       state_nxt = S_CRC;
                         else if (!hold_full) state_nxt = S_END;
                      end
         S_CRC:       if (stop_i || crc_cnt == 4'd15) state_nxt = S_END;
         S_END:       state_nxt = abort ? S_IDLE : S_STAT_WAIT;
         S_STAT_WAIT: if (!dat0_i) state_nxt = S_STAT;
                      else if (timeout) state_nxt = S_IDLE;
         S_STAT:      if (stat_cnt == 2'd3) state_nxt = S_BUSY;
         S_BUSY:      if (dat0_i) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      dat_o    = 4'hF;
      dat_oe_o = 4'h0;
      case (state)
         S_START: begin dat_oe_o = lanes; dat_o = ~lanes;   end
         S_DATA:  begin dat_oe_o = lanes; dat_o = data_bits; end
         S_CRC:   begin dat_oe_o = lanes; dat_o = crc_bits;  end
         S_END:   dat_oe_o = lanes;
         default: ;
      endcase
   end

   assign dat_ready_o = !hold_full && (words_req < words_total) &&
                        (state == S_FETCH || state == S_START || state == S_DATA);
   assign busy_o      = (state != S_IDLE);
   assign underflow_o = underflow;
   assign done_o      = done_q;
   assign crc_err_o   = crc_err_q;
   assign status_o    = status_q;

   always_ff @(posedge sd_clk_i) begin
      if (rst_i) begin
         bus4        <= 1'b0;
         words_total <= '0;
         words_req   <= '0;
         words_sent  <= '0;
         hold_dat    <= '0;
         hold_full   <= 1'b0;
         shreg       <= '0;
         bit_cnt     <= '0;
         crc_cnt     <= '0;
         to_cnt      <= '0;
         stat_cnt    <= '0;
         tok         <= '0;
         abort       <= 1'b0;
         status_q    <= '0;
         done_q      <= 1'b0;
         crc_err_q   <= 1'b0;
         for (int k = 0; k < 4; k++) crc_q[k] <= '0;
      end else begin
         done_q    <= 1'b0;
         crc_err_q <= 1'b0;
         if (word_hs) words_req <= words_req + WW'(1);
         if (state != S_END && state_nxt == S_END) abort <= stop_i || underflow;
         case (state)
            S_IDLE: if (start_ok) begin
               bus4        <= bus_4bit_i;
               words_total <= block_len_i[BlockLenWidth-1:2];
               words_req   <= '0;
               words_sent  <= '0;
               hold_full   <= 1'b0;
               crc_cnt     <= '0;
            end
            S_FETCH: if (word_hs) begin
               shreg   <= byte_rev(dat_i);
               bit_cnt <= '0;
               for (int k = 0; k < 4; k++) crc_q[k] <= '0;
            end
            S_START: if (word_hs) begin
               hold_dat  <= dat_i;
               hold_full <= 1'b1;
            end
            S_DATA: begin
               shreg   <= bus4 ? {shreg[27:0], 4'hF} : {shreg[30:0], 1'b1};
               bit_cnt <= bit_cnt + 5'd1;
               for (int k = 0; k < 4; k++) crc_q[k] <= crc_step(crc_q[k], data_bits[k]);
               if (word_hs) begin
                  hold_dat  <= dat_i;
                  hold_full <= 1'b1;
               end
               if (last_slot && !last_word && hold_full) begin
                  shreg      <= byte_rev(hold_dat);
                  hold_full  <= 1'b0;
                  words_sent <= words_sent + WW'(1);
                  bit_cnt    <= '0;
               end
            end
            S_CRC: begin
               for (int k = 0; k < 4; k++) crc_q[k] <= {crc_q[k][14:0], 1'b0};
               crc_cnt <= crc_cnt + 4'd1;
            end
            S_END: begin
               to_cnt   <= '0;
               stat_cnt <= '0;
               crc_cnt  <= '0;
               if (abort) done_q <= 1'b1;
            end
            S_STAT_WAIT: if (dat0_i) begin
               to_cnt <= to_cnt + TW'(1);
               if (timeout) begin
                  status_q  <= 3'b000;
                  done_q    <= 1'b1;
                  crc_err_q <= 1'b1;
               end
            end
            S_STAT: begin
               stat_cnt <= stat_cnt + 2'd1;
               tok      <= {tok[0], dat0_i};
               if (stat_cnt == 2'd2) status_q <= {tok, dat0_i};
            end
            S_BUSY: if (dat0_i) begin
               done_q    <= 1'b1;
               crc_err_q <= (status_q != 3'b010);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Self-checking bench for sd_dat_tx: random and directed blocks against a bit-stream / polynomial-division model.
module tb_sd_dat_tx;
   localparam int BLW = 12;
   localparam int STO = 8;

   logic           sd_clk_i = 1'b0;
   logic           rst_i, start_i, bus_4bit_i, stop_i, dat_valid_i, dat0_i;
   logic [BLW-1:0] block_len_i;
   logic [31:0]    dat_i;
   logic           dat_ready_o, busy_o, done_o, crc_err_o, underflow_o;
   logic [3:0]     dat_o, dat_oe_o;
   logic [2:0]     status_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sd_clk_i = ~sd_clk_i;

   sd_dat_tx #(.BlockLenWidth(BLW), .StatusTimeout(STO)) dut (
      .sd_clk_i(sd_clk_i), .rst_i(rst_i), .start_i(start_i), .bus_4bit_i(bus_4bit_i),
      .block_len_i(block_len_i), .stop_i(stop_i), .dat_i(dat_i), .dat_valid_i(dat_valid_i),
      .dat_ready_o(dat_ready_o), .dat_o(dat_o), .dat_oe_o(dat_oe_o), .dat0_i(dat0_i),
      .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .crc_err_o(crc_err_o),
      .underflow_o(underflow_o));

   // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
   function automatic logic [15:0] crc16_div(input bit bits[$]);
      logic [16:0] rem;
      rem = '0;
      for (int i = 0; i < bits.size() + 16; i++) begin
         rem = {rem[15:0], (i < bits.size()) ? bits[i] : 1'b0};
         if (rem[16]) rem = rem ^ 17'h11021;
      end
      return rem[15:0];
   endfunction

   function automatic void build_expected(input bit b4, input logic [7:0] bytes[$], output logic [3:0] exp[$]);
      bit l0[$], l1[$], l2[$], l3[$];
      logic [15:0] c0, c1, c2, c3;
      logic [3:0] nib;
      exp = {};
      exp.push_back(b4 ? 4'h0 : 4'hE);
      foreach (bytes[i]) begin
         if (b4) begin
            for (int h = 1; h >= 0; h--) begin
               nib = (h == 1) ? bytes[i][7:4] : bytes[i][3:0];
               exp.push_back(nib);
               l0.push_back(nib[0]); l1.push_back(nib[1]); l2.push_back(nib[2]); l3.push_back(nib[3]);
            end
         end else begin
            for (int b = 7; b >= 0; b--) begin
               exp.push_back({3'b111, bytes[i][b]});
               l0.push_back(bytes[i][b]);
            end
         end
      end
      c0 = crc16_div(l0); c1 = crc16_div(l1); c2 = crc16_div(l2); c3 = crc16_div(l3);
      for (int i = 15; i >= 0; i--)
         exp.push_back(b4 ? {c3[i], c2[i], c1[i], c0[i]} : {3'b111, c0[i]});
      exp.push_back(4'hF);
   endfunction

   function automatic void make_words(input logic [7:0] bytes[$], output logic [31:0] words[$]);
      words = {};
      for (int i = 0; i + 3 < bytes.size(); i += 4)
         words.push_back({bytes[i+3], bytes[i+2], bytes[i+1], bytes[i]});
   endfunction

   function automatic int count_diff(input logic [3:0] a[$], input logic [3:0] b[$], input int n, output int first);
      int d;
      d = 0; first = -1;
      for (int i = 0; i < n; i++)
         if (i >= a.size() || i >= b.size() || a[i] !== b[i]) begin
            d++;
            if (first < 0) first = i;
         end
      return d;
   endfunction

   // Starts a block, feeds words, records dat_o of every driven cycle until the bus is released.
   task automatic send_block(input bit b4, input int nbytes, input logic [31:0] words[$], input int hold_after,
                             input int stop_slot, output logic [3:0] seq[$], output int und_slot,
                             output int oe_bad, output logic rel_done, output bit expired);
      int idx;
      bit started;
      logic [3:0] lanes;
      seq = {}; und_slot = -1; oe_bad = 0; rel_done = 1'b0; expired = 1'b1; idx = 0; started = 1'b0;
      lanes = b4 ? 4'hF : 4'h1;
      @(negedge sd_clk_i);
      start_i = 1'b1; bus_4bit_i = b4; block_len_i = BLW'(nbytes); dat_valid_i = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge sd_clk_i);
         if (dat_oe_o != 4'h0) begin
            started = 1'b1;
            seq.push_back(dat_o);
            if (dat_oe_o !== lanes) oe_bad++;
            if (underflow_o === 1'b1) und_slot = seq.size() - 2;
         end else if (started) begin
            rel_done = done_o; expired = 1'b0; stop_i = 1'b0; dat_valid_i = 1'b0;
            return;
         end
         start_i = 1'b0;
         stop_i = (stop_slot >= 0) && (dat_oe_o != 4'h0) && (seq.size() - 2 == stop_slot);
         dat_valid_i = (idx < words.size()) && (hold_after < 0 || idx < hold_after);
         if (dat_valid_i) dat_i = words[idx];
         if (dat_valid_i && dat_ready_o) idx++;
      end
      start_i = 1'b0; stop_i = 1'b0; dat_valid_i = 1'b0;
   endtask

   // Card side of the status phase, starting at the first released negedge.
   task automatic card_respond(input bit silent, input int d, input logic [2:0] tok, input int busy,
                               output int done_idx, output logic [2:0] st, output logic err, output logic done_next);
      done_idx = -1; st = 3'b000; err = 1'b0; done_next = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (i > 0) begin
            @(negedge sd_clk_i);
            if (done_o === 1'b1) begin
               done_idx = i; st = status_o; err = crc_err_o; dat0_i = 1'b1;
               @(negedge sd_clk_i);
               done_next = done_o;
               return;
            end
         end
         if (silent || i < d)        dat0_i = 1'b1;
         else if (i == d)            dat0_i = 1'b0;
         else if (i <= d + 3)        dat0_i = tok[2 - (i - d - 1)];
         else if (i == d + 4)        dat0_i = 1'b1;
         else if (i <= d + 4 + busy) dat0_i = 1'b0;
         else                        dat0_i = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; bus_4bit_i = 1'b0; block_len_i = '0; stop_i = 1'b0;
      dat_i = '0; dat_valid_i = 1'b0; dat0_i = 1'b1;
      repeat (3) @(negedge sd_clk_i);
      n_checks++; if (dat_o !== 4'hF)      begin n_fail++; $display("FAIL rst_dat: got %h expected f", dat_o); end
      n_checks++; if (dat_oe_o !== 4'h0)   begin n_fail++; $display("FAIL rst_oe: got %h expected 0", dat_oe_o); end
      n_checks++; if (dat_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", dat_ready_o); end
      n_checks++; if (busy_o !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
      n_checks++; if ({done_o, crc_err_o, underflow_o} !== 3'b000)
         begin n_fail++; $display("FAIL rst_pulses: got %b expected 000", {done_o, crc_err_o, underflow_o}); end
      n_checks++; if (status_o !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b expected 000", status_o); end
      rst_i = 1'b0;
      @(negedge sd_clk_i);
   endtask

   task automatic test_ignored_start();
      start_i = 1'b1; block_len_i = BLW'(3); bus_4bit_i = 1'b1;
      @(negedge sd_clk_i);
      start_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_len_start: busy %b expected 0", busy_o); end
      start_i = 1'b1; stop_i = 1'b1; block_len_i = BLW'(64);
      @(negedge sd_clk_i);
      start_i = 1'b0; stop_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL start_with_stop: busy %b expected 0", busy_o); end
   endtask

   task automatic test_1bit_ff();
      logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] exp[$], seq[$];
      int und, oe_bad, didx, nd, first; logic rel_done, err, dn; bit expired; logic [2:0] st; logic [15:0] crc0;
      for (int i = 0; i < 512; i++) bytes.push_back(8'hFF);
      make_words(bytes, words);
      build_expected(1'b0, bytes, exp);
      send_block(1'b0, 512, words, -1, -1, seq, und, oe_bad, rel_done, expired);
      n_checks++; if (expired || seq.size() != 1 + 4096 + 16 + 1)
         begin n_fail++; $display("FAIL 1bit_len: got %0d cycles (expired %0d) expected %0d", seq.size(), expired, 4114); end
      nd = count_diff(seq, exp, exp.size(), first);
      n_checks++; if (nd != 0) begin n_fail++; $display("FAIL 1bit_seq: %0d mismatches, first at %0d", nd, first); end
      crc0 = '0;
      for (int i = 0; i < 16; i++) if (4097 + i < seq.size()) crc0[15 - i] = seq[4097 + i][0];
      n_checks++; if (crc0 !== 16'h7FA1) begin n_fail++; $display("FAIL 1bit_crc: got %h expected 7fa1", crc0); end
      n_checks++; if (oe_bad != 0) begin n_fail++; $display("FAIL 1bit_oe: %0d cycles with wrong lanes, expected 0", oe_bad); end
      card_respond(1'b0, 2, 3'b010, 5, didx, st, err, dn);
      n_checks++; if (didx != 2 + 6 + 5) begin n_fail++; $display("FAIL 1bit_done_time: got %0d expected %0d", didx, 13); end
      n_checks++; if (st !== 3'b010) begin n_fail++; $display("FAIL 1bit_status: got %b expected 010", st); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL 1bit_crc_err: got %b expected 0", err); end
      n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL 1bit_done_pulse: done after pulse %b expected 0", dn); end
   endtask

   task automatic test_4bit_inc();
      logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] exp[$], seq[$], first4, want4;
      int und, oe_bad, didx, nd, first; logic rel_done, err, dn; bit expired; logic [2:0] st;
      int d, busy;
      for (int i = 0; i < 512; i++) bytes.push_back(8'(i));
      make_words(bytes, words);
      build_expected(1'b1, bytes, exp);
      send_block(1'b1, 512, words, -1, -1, seq, und, oe_bad, rel_done, expired);
      n_checks++; if (expired || seq.size() != 1042)
         begin n_fail++; $display("FAIL 4bit_len: got %0d driven cycles expected 1042", seq.size()); end
      want4 = 4'h1; first4 = (seq.size() > 4) ? seq[4] : 4'hx;
      n_checks++; if (seq.size() < 5 || seq[1] !== 4'h0 || seq[2] !== 4'h0 || seq[3] !== 4'h0 || first4 !== want4)
         begin n_fail++; $display("FAIL 4bit_first_slots: got slot3 %h expected 0,0,0,1", first4); end
      nd = count_diff(seq, exp, exp.size(), first);
      n_checks++; if (nd != 0) begin n_fail++; $display("FAIL 4bit_seq: %0d mismatches, first at %0d", nd, first); end
      nd = 0;
      for (int i = 1025; i < 1041; i++) if (i >= seq.size() || seq[i] !== exp[i]) nd++;
      n_checks++; if (nd != 0) begin n_fail++; $display("FAIL 4bit_crc: %0d of 16 CRC slots wrong, expected 0", nd); end
      d = $urandom_range(0, 5); busy = $urandom_range(0, 6);
      card_respond(1'b0, d, 3'b010, busy, didx, st, err, dn);
      n_checks++; if (didx != d + 6 + busy || st !== 3'b010 || err !== 1'b0)
         begin n_fail++; $display("FAIL 4bit_status: done@%0d st %b err %b expected done@%0d st 010 err 0", didx, st, err, d + 6 + busy); end
   endtask

   task automatic test_bad_token();
      logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] exp[$], seq[$];
      int und, oe_bad, didx, nd, first; logic rel_done, err, dn; bit expired; logic [2:0] st;
      for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
      make_words(bytes, words);
      build_expected(1'b1, bytes, exp);
      send_block(1'b1, 8, words, -1, -1, seq, und, oe_bad, rel_done, expired);
      nd = count_diff(seq, exp, exp.size(), first);
      n_checks++; if (expired || nd != 0 || seq.size() != exp.size())
         begin n_fail++; $display("FAIL badtok_seq: %0d mismatches first %0d, len %0d expected %0d", nd, first, seq.size(), exp.size()); end
      card_respond(1'b0, 1, 3'b101, 2, didx, st, err, dn);
      n_checks++; if (st !== 3'b101) begin n_fail++; $display("FAIL badtok_status: got %b expected 101", st); end
      n_checks++; if (didx != 1 + 6 + 2 || err !== 1'b1)
         begin n_fail++; $display("FAIL badtok_err: done@%0d err %b expected done@9 err 1", didx, err); end
   endtask

   task automatic test_underflow();
      logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] exp[$], seq[$];
      int und, oe_bad, nd, first; logic rel_done; bit expired;
      for (int i = 0; i < 16; i++) bytes.push_back(8'($urandom));
      make_words(bytes, words);
      build_expected(1'b1, bytes, exp);
      send_block(1'b1, 16, words, 1, -1, seq, und, oe_bad, rel_done, expired);
      n_checks++; if (und != 7) begin n_fail++; $display("FAIL underflow_slot: got %0d expected 7", und); end
      nd = count_diff(seq, exp, 9, first);
      n_checks++; if (expired || seq.size() != 10 || nd != 0 || seq[9] !== 4'hF)
         begin n_fail++; $display("FAIL underflow_seq: len %0d mismatches %0d expected len 10 ending f", seq.size(), nd); end
      n_checks++; if (rel_done !== 1'b1 || busy_o !== 1'b0 || crc_err_o !== 1'b0)
         begin n_fail++; $display("FAIL underflow_done: done %b busy %b err %b expected 1 0 0", rel_done, busy_o, crc_err_o); end
   endtask

   task automatic test_stop();
      logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] exp[$], seq[$];
      int und, oe_bad, nd, first; logic rel_done; bit expired;
      for (int i = 0; i < 512; i++) bytes.push_back(8'($urandom));
      make_words(bytes, words);
      build_expected(1'b1, bytes, exp);
      send_block(1'b1, 512, words, -1, 100, seq, und, oe_bad, rel_done, expired);
      nd = count_diff(seq, exp, 102, first);
      n_checks++; if (expired || seq.size() != 103 || nd != 0)
         begin n_fail++; $display("FAIL stop_seq: len %0d mismatches %0d expected len 103", seq.size(), nd); end
      n_checks++; if (seq.size() < 103 || seq[seq.size() - 1] !== 4'hF)
         begin n_fail++; $display("FAIL stop_end: last driven %h expected f", (seq.size() > 0) ? seq[seq.size() - 1] : 4'hx); end
      n_checks++; if (rel_done !== 1'b1 || dat_oe_o !== 4'h0 || busy_o !== 1'b0)
         begin n_fail++; $display("FAIL stop_idle: done %b oe %h busy %b expected 1 0 0", rel_done, dat_oe_o, busy_o); end
   endtask

   task automatic test_timeout();
      logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] seq[$];
      int und, oe_bad, didx; logic rel_done, err, dn; bit expired; logic [2:0] st;
      for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
      make_words(bytes, words);
      send_block(1'b1, 8, words, -1, -1, seq, und, oe_bad, rel_done, expired);
      card_respond(1'b1, 0, 3'b000, 0, didx, st, err, dn);
      n_checks++; if (didx != STO) begin n_fail++; $display("FAIL timeout_time: done@%0d expected %0d", didx, STO); end
      n_checks++; if (err !== 1'b1 || st !== 3'b000)
         begin n_fail++; $display("FAIL timeout_err: err %b st %b expected 1 000", err, st); end
   endtask

   task automatic test_reset_mid();
      @(negedge sd_clk_i);
      start_i = 1'b1; bus_4bit_i = 1'b1; block_len_i = BLW'(512); dat_valid_i = 1'b1; dat_i = $urandom;
      @(negedge sd_clk_i);
      start_i = 1'b0;
      repeat (20) @(negedge sd_clk_i);
      n_checks++; if (dat_oe_o !== 4'hF) begin n_fail++; $display("FAIL rstmid_pre: oe %h expected f", dat_oe_o); end
      rst_i = 1'b1;
      @(negedge sd_clk_i);
      n_checks++; if (dat_oe_o !== 4'h0 || busy_o !== 1'b0 || dat_o !== 4'hF || dat_ready_o !== 1'b0)
         begin n_fail++; $display("FAIL rstmid: oe %h busy %b dat %h rdy %b expected 0 0 f 0", dat_oe_o, busy_o, dat_o, dat_ready_o); end
      rst_i = 1'b0; dat_valid_i = 1'b0;
      @(negedge sd_clk_i);
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 6; it++) begin
         logic [7:0] bytes[$]; logic [31:0] words[$]; logic [3:0] exp[$], seq[$];
         int und, oe_bad, didx, nd, first, nw, d, busy; logic rel_done, err, dn; bit expired, b4;
         logic [2:0] st, tok;
         b4 = 1'($urandom); nw = $urandom_range(1, 12);
         d = $urandom_range(0, 5); busy = $urandom_range(0, 6); tok = 3'($urandom);
         for (int i = 0; i < 4 * nw; i++) bytes.push_back(8'($urandom));
         make_words(bytes, words);
         build_expected(b4, bytes, exp);
         send_block(b4, 4 * nw + $urandom_range(0, 3), words, -1, -1, seq, und, oe_bad, rel_done, expired);
         nd = count_diff(seq, exp, exp.size(), first);
         n_checks++; if (expired || nd != 0 || seq.size() != exp.size() || oe_bad != 0)
            begin n_fail++; $display("FAIL b2b_seq[%0d]: %0d mismatches first %0d, len %0d expected %0d", it, nd, first, seq.size(), exp.size()); end
         card_respond(1'b0, d, tok, busy, didx, st, err, dn);
         n_checks++; if (didx != d + 6 + busy || st !== tok || err !== (tok != 3'b010))
            begin n_fail++; $display("FAIL b2b_status[%0d]: done@%0d st %b err %b expected done@%0d st %b", it, didx, st, err, d + 6 + busy, tok); end
      end
   endtask

   initial begin
      test_reset();
      test_ignored_start();
      test_1bit_ff();
      test_4bit_inc();
      test_bad_token();
      test_underflow();
      test_stop();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
